// File: rtl/seq_divider_pkg.sv
// Shared widths, FSM encoding and sign helper for the sequential divider.
package seq_divider_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned DIV_CNT_WIDTH = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_CALC = 2'd1,
    DIV_STATE_FIX  = 2'd2
  } div_state_e;

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] x,
                                                     input logic                  neg);
    return neg ? (~x + DATA_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/ready divide handshake between the MDU (master) and the divider (slave).
interface seq_divider_if;
  import seq_divider_pkg::*;

  logic [DATA_WIDTH-1:0] dividend_i;
  logic [DATA_WIDTH-1:0] divisior_i;
  logic                  signed_i;
  logic                  start_i;
  logic [DATA_WIDTH-1:0] quotient_o;
  logic [DATA_WIDTH-1:0] remainder_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output dividend_i, divisior_i, signed_i, start_i,
    input  quotient_o, remainder_o, ready_o, busy_o
  );

  modport slave (
    input  dividend_i, divisior_i, signed_i, start_i,
    output quotient_o, remainder_o, ready_o, busy_o
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring iteration: shift in the next dividend bit, trial-subtract, select.
module seq_divider_div_step
  import seq_divider_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] dvd_i,
  input  logic [DATA_WIDTH-1:0] dvs_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] dvd_o,
  output logic                  q_bit_o
);

  logic [DATA_WIDTH:0] shifted_rem;
  logic [DATA_WIDTH:0] trial;

  assign shifted_rem = {rem_i, dvd_i[DATA_WIDTH-1]};
  assign trial       = shifted_rem - {1'b0, dvs_i};
  assign q_bit_o     = ~trial[DATA_WIDTH];
  assign rem_o       = q_bit_o ? trial[DATA_WIDTH-1:0] : shifted_rem[DATA_WIDTH-1:0];
  // Low bit is vacated here; the caller merges the quotient bit in.
  assign dvd_o       = {dvd_i[DATA_WIDTH-2:0], 1'b0};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, fixed DATA_WIDTH+2 cycle latency.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  seq_divider_if.slave  div_if
);

  div_state_e               state;
  logic [DIV_CNT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]    rem_q;
  logic [DATA_WIDTH-1:0]    dvd_q;
  logic [DATA_WIDTH-1:0]    dvs_q;
  logic                     q_neg_q;
  logic                     r_neg_q;
  logic                     dz_q;

  logic [DATA_WIDTH-1:0]    rem_nxt;
  logic [DATA_WIDTH-1:0]    dvd_shift;
  logic                     q_bit;
  logic                     dvd_neg_c;
  logic                     dvs_neg_c;

  assign dvd_neg_c = div_if.signed_i & div_if.dividend_i[DATA_WIDTH-1];
  assign dvs_neg_c = div_if.signed_i & div_if.divisior_i[DATA_WIDTH-1];

  seq_divider_div_step u_step (
    .rem_i   (rem_q),
    .dvd_i   (dvd_q),
    .dvs_i   (dvs_q),
    .rem_o   (rem_nxt),
    .dvd_o   (dvd_shift),
    .q_bit_o (q_bit)
  );

  // The dividend register doubles as the quotient accumulator during CALC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= DIV_STATE_IDLE;
      cnt                <= '0;
      rem_q              <= '0;
      dvd_q              <= '0;
      dvs_q              <= '0;
      q_neg_q            <= 1'b0;
      r_neg_q            <= 1'b0;
      dz_q               <= 1'b0;
      div_if.quotient_o  <= '0;
      div_if.remainder_o <= '0;
      div_if.ready_o     <= 1'b0;
      div_if.busy_o      <= 1'b0;
    end else begin
      case (state)
        DIV_STATE_IDLE: begin
          if (div_if.start_i) begin
            rem_q          <= '0;
            dvd_q          <= cond_neg(div_if.dividend_i, dvd_neg_c);
            dvs_q          <= cond_neg(div_if.divisior_i, dvs_neg_c);
            q_neg_q        <= dvd_neg_c ^ dvs_neg_c;
            r_neg_q        <= dvd_neg_c;
            dz_q           <= (div_if.divisior_i == '0);
            cnt            <= '0;
            div_if.ready_o <= 1'b0;
            div_if.busy_o  <= 1'b1;
            state          <= DIV_STATE_CALC;
          end
        end
        DIV_STATE_CALC: begin
          rem_q <= rem_nxt;
          dvd_q <= dvd_shift | DATA_WIDTH'(q_bit);
          if (cnt == DIV_CNT_WIDTH'(DATA_WIDTH - 1)) begin
            cnt   <= '0;
            state <= DIV_STATE_FIX;
          end else begin
            cnt <= cnt + DIV_CNT_WIDTH'(1);
          end
        end
        DIV_STATE_FIX: begin
          // Divide by zero leaves the dividend magnitude in rem_q, so only the quotient needs overriding.
          div_if.quotient_o  <= dz_q ? '1 : cond_neg(dvd_q, q_neg_q);
          div_if.remainder_o <= cond_neg(rem_q, r_neg_q);
          div_if.ready_o     <= 1'b1;
          div_if.busy_o      <= 1'b0;
          state              <= DIV_STATE_IDLE;
        end
        default: state <= DIV_STATE_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring divider that is the responder side of the MDU start/busy/ready divide handshake. It accepts one signed or unsigned 32-bit divide per request and returns a quotient and remainder after a fixed latency. It holds both results steady until the next divide completes. It sits under the MDU and serves the DIV and DIVU operations that load HI (remainder) and LO (quotient).

## Interface
- DATA_WIDTH, 32, operand and result width; also the iteration count.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- dividend_i  in  DATA_WIDTH  dividend; sampled only when a start is accepted.
- divisior_i  in  DATA_WIDTH  divisor; sampled only when a start is accepted. The port name is spelled this way to stay pin-compatible with the MDU.
- signed_i  in  1  1 = two's-complement divide, 0 = unsigned; sampled only when a start is accepted.
- start_i  in  1  divide request.
- quotient_o  out  DATA_WIDTH  quotient; reset value 0.
- remainder_o  out  DATA_WIDTH  remainder; reset value 0.
- ready_o  out  1  result valid; a level signal; reset value 0.
- busy_o  out  1  divide in progress; reset value 0.

## Operation
- **States:** IDLE, CALC, FIX. ready_o is a separate flag register.
- **Accept:** a start is accepted when start_i=1 and busy_o=0 (IDLE state), including cycles where ready_o=1. On acceptance:
  - latch signed_i;
  - latch the operand magnitudes (negate a negative operand only when signed);
  - latch the result signs: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend);
  - latch a divide-by-zero flag;
  - clear the partial remainder, clear the iteration counter, clear ready_o, and go to CALC.
- **Start while busy:** start_i while busy_o=1 is ignored. No queuing. In-flight operands are unaffected.
- **CALC:** one restoring step per cycle for DATA_WIDTH cycles, MSB first:
  - shift {partial remainder, dividend magnitude} left by 1;
  - trial-subtract the divisor magnitude using a (DATA_WIDTH+1)-bit subtract;
  - if the result is non-negative, keep the difference and set quotient bit 1; otherwise restore and set it to 0.
  - The counter wraps from DATA_WIDTH-1 to 0 and the state moves to FIX.
- **FIX (one cycle):** apply the latched signs by two's-complement negation. Write quotient_o and remainder_o. Set ready_o=1. Return to IDLE.
- **Signed semantics:** the quotient truncates toward zero and the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0. This is the natural wrap; no flag is raised.
- **Divide by zero:** quotient_o = all ones and remainder_o = the original dividend_i, for both signed and unsigned. Latency is unchanged and no exception is raised.
- **Output hold:** quotient_o and remainder_o change only in FIX. They hold otherwise, including while the next divide is in CALC.
- **Reset:** rst_i at any time, including mid-CALC, aborts the operation.
  - State returns to IDLE.
  - All outputs and internal registers return to 0.
  - No ready_o is produced for the aborted divide.

## Timing
- Acceptance at the edge ending cycle k. busy_o=1 in cycles k+1 .. k+DATA_WIDTH+1 (CALC, then FIX).
- ready_o rises and results become valid in cycle k+DATA_WIDTH+2, which is k+34 for width 32.
- busy_o and ready_o are never both 1.
- ready_o stays 1 until the edge that accepts the next start; it is 0 from the following cycle.
- The initiator detects completion on the 0→1 edge of ready_o.
- Back-to-back: a start held high while ready_o=1 is accepted immediately. The minimum interval between acceptances is DATA_WIDTH+2 cycles.
- No combinational path from any input to any output.

## Structure
- The shared include Defines.v holds:
  - state encodings DIV_STATE_IDLE, DIV_STATE_CALC, DIV_STATE_FIX;
  - DIV_CNT_WIDTH = clog2(DATA_WIDTH).
- One natural sub-module, div_step: the combinational one-iteration shift/trial-subtract/select. Its outputs are the next partial remainder, the next dividend shift value and the quotient bit.
- Sign fix-up and the FSM stay in the top module.

## Test plan
- **Unsigned:** start with 100 / 7, signed_i=0 → busy_o=1 for 33 cycles; in cycle k+34 ready_o=1, quotient 14, remainder 2.
- **Signed:**
  - -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7 / -2 → quotient 0xFFFFFFFD, remainder 1.
  - Same operands unsigned: 0xFFFFFFF9 / 2 → quotient 0x7FFFFFFC, remainder 1.
- **Overflow and zero:**
  - 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0.
  - 0x1234 / 0 → quotient 0xFFFFFFFF, remainder 0x1234, same latency.
- **Handshake:**
  - Pulse start_i and change operands at k+5 and at k+20 → ignored; the result matches the operands from cycle k.
  - Hold start_i high → a second acceptance on the ready cycle; ready_o drops the next cycle; results hold until the second FIX.
- **Reset mid-operation:** assert rst_i at k+10 for one cycle → all outputs 0 the next cycle, no ready_o edge afterwards. A fresh start then completes with correct values.
